// File: rtl/enigma_rotor_return.sv
// Reverse-path (post-reflector) stage of an Enigma rotor I, with position register,
// stepping and turnover carry. Define ROTOR_RING_SETTING_EN to add the ring_in port and ring register.
module enigma_rotor_return (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] in_letter,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] out_letter,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_err,
  input  logic       step,
  input  logic       load,
  input  logic [4:0] pos_in,
`ifdef ROTOR_RING_SETTING_EN
  input  logic [4:0] ring_in,
`endif
  output logic [4:0] pos,
  output logic       carry
);

  localparam logic [4:0] NOTCH = 5'd16;

  logic [4:0] pos_q, pos_d;
  logic [4:0] outLetter_q, outLetter_d;
  logic       outValid_q, outValid_d;
  logic       outErr_q, outErr_d;
  logic       carry_q, carry_d;
  logic [4:0] ring;

  logic       accept;
  logic [5:0] offRaw;
  logic [5:0] off;
  logic [5:0] idxRaw;
  logic [4:0] idx;
  logic [4:0] inv;
  logic [5:0] outRaw;
  logic [4:0] mapped;

  function automatic logic [4:0] mod26(input logic [4:0] v);
    return (v >= 5'd26) ? v - 5'd26 : v;
  endfunction

  // Inverse wiring of rotor I: UWYGADFPVZBECKMTHXSLRINQOJ
  function automatic logic [4:0] invLookup(input logic [4:0] i);
    logic [4:0] r;
    case (i)
      5'd0:  r = 5'd20;  5'd1:  r = 5'd22;  5'd2:  r = 5'd24;  5'd3:  r = 5'd6;
      5'd4:  r = 5'd0;   5'd5:  r = 5'd3;   5'd6:  r = 5'd5;   5'd7:  r = 5'd15;
      5'd8:  r = 5'd21;  5'd9:  r = 5'd25;  5'd10: r = 5'd1;   5'd11: r = 5'd4;
      5'd12: r = 5'd2;   5'd13: r = 5'd10;  5'd14: r = 5'd12;  5'd15: r = 5'd19;
      5'd16: r = 5'd7;   5'd17: r = 5'd23;  5'd18: r = 5'd18;  5'd19: r = 5'd11;
      5'd20: r = 5'd17;  5'd21: r = 5'd8;   5'd22: r = 5'd13;  5'd23: r = 5'd16;
      5'd24: r = 5'd14;  5'd25: r = 5'd9;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

`ifdef ROTOR_RING_SETTING_EN
  logic [4:0] ring_q, ring_d;
  assign ring = ring_q;

  always_comb begin
    ring_d = ring_q;
    if (load) ring_d = mod26(ring_in);
  end

  always_ff @(posedge clk) begin
    if (rst) ring_q <= 5'd0;
    else     ring_q <= ring_d;
  end
`else
  assign ring = 5'd0;
`endif

  assign in_ready = !outValid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // pos - ring is folded into one offset so each add/subtract needs only one +-26 fix-up.
  always_comb begin
    offRaw = {1'b0, pos_q} - {1'b0, ring};
    off    = offRaw[5] ? offRaw + 6'd26 : offRaw;
    idxRaw = {1'b0, in_letter} + off;
    idx    = 5'((idxRaw >= 6'd26) ? idxRaw - 6'd26 : idxRaw);
    inv    = invLookup(idx);
    outRaw = {1'b0, inv} - off;
    mapped = 5'(outRaw[5] ? outRaw + 6'd26 : outRaw);
  end

  always_comb begin
    outLetter_d = outLetter_q;
    outErr_d    = outErr_q;
    outValid_d  = outValid_q;
    pos_d       = pos_q;
    carry_d     = 1'b0;

    if (accept) begin
      outValid_d = 1'b1;
      if (in_letter >= 5'd26) begin
        outLetter_d = 5'd0;
        outErr_d    = 1'b1;
      end else begin
        outLetter_d = mapped;
        outErr_d    = 1'b0;
      end
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end

    // Load wins over step and never produces a turnover pulse.
    if (load) begin
      pos_d = mod26(pos_in);
    end else if (step) begin
      pos_d   = (pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1;
      carry_d = (pos_q == NOTCH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q       <= 5'd0;
      outLetter_q <= 5'd0;
      outValid_q  <= 1'b0;
      outErr_q    <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      outLetter_q <= outLetter_d;
      outValid_q  <= outValid_d;
      outErr_q    <= outErr_d;
      carry_q     <= carry_d;
    end
  end

  assign out_letter = outLetter_q;
  assign out_valid  = outValid_q;
  assign out_err    = outErr_q;
  assign pos        = pos_q;
  assign carry      = carry_q;

endmodule

// File: tb/tb_enigma_rotor_return.sv
// Directed self-checking bench for enigma_rotor_return; expected mappings come from
// hand values and a search of the forward rotor I wiring.
module tb_enigma_rotor_return;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] in_letter;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] out_letter;
   logic       out_valid;
   logic       out_ready;
   logic       out_err;
   logic       step;
   logic       load;
   logic [4:0] pos_in;
   logic [4:0] ring_in;
   logic [4:0] pos;
   logic       carry;

   int vectors = 0;
   int miscompares = 0;

   int fwd [26] = '{4, 10, 12, 5, 11, 6, 3, 16, 21, 25, 13, 19, 14,
                    22, 24, 7, 23, 20, 18, 15, 0, 8, 1, 17, 2, 9};

   always #5 clk = ~clk;

   enigma_rotor_return dut (
      .clk        (clk),
      .rst        (rst),
      .in_letter  (in_letter),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_letter (out_letter),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_err    (out_err),
      .step       (step),
      .load       (load),
      .pos_in     (pos_in),
`ifdef ROTOR_RING_SETTING_EN
      .ring_in    (ring_in),
`endif
      .pos        (pos),
      .carry      (carry)
   );

   // Inverse found by searching the forward wiring, independent of the DUT's inverse table.
   function automatic int expLetter(input int i, input int p, input int r);
      int target;
      target = (i + p - r + 52) % 26;
      for (int o = 0; o < 26; o++)
         if (fwd[(o + p - r + 52) % 26] == target) return o;
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Presents one letter for a single cycle; outputs are sampled on the following negedge.
   task automatic applyStimulus(input logic [4:0] letter);
      in_letter = letter;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
   endtask

   task automatic loadPos(input logic [4:0] p, input logic [4:0] r);
      load    = 1'b1;
      pos_in  = p;
      ring_in = r;
      @(negedge clk);
      load    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; in_letter = 5'd0; in_valid = 1'b0; out_ready = 1'b1;
      step = 1'b0; load = 1'b0; pos_in = 5'd0; ring_in = 5'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_pos", pos, 0);
      checkOutput("reset_carry", carry, 0);
      checkOutput("reset_in_ready", in_ready, 1);
      checkOutput("reset_out_letter", out_letter, 0);
      checkOutput("reset_out_err", out_err, 0);

      applyStimulus(5'd4);
      checkOutput("E_at_0_valid", out_valid, 1);
      checkOutput("E_at_0_letter", out_letter, 0);
      checkOutput("E_at_0_err", out_err, 0);

      loadPos(5'd1, 5'd0);
      checkOutput("load1_pos", pos, 1);
      applyStimulus(5'd9);
      checkOutput("J_at_1_letter", out_letter, 0);

      for (int i = 0; i <= 26; i++) begin
         if (i > 0) begin
            checkOutput($sformatf("stream_valid_%0d", i - 1), out_valid, 1);
            checkOutput($sformatf("stream_letter_%0d", i - 1), out_letter, expLetter(i - 1, 1, 0));
         end
         if (i < 26) begin
            in_letter = 5'(i);
            in_valid  = 1'b1;
         end else begin
            in_valid  = 1'b0;
         end
         @(negedge clk);
      end
      checkOutput("stream_drained", out_valid, 0);

      loadPos(5'd16, 5'd0);
      checkOutput("load16_pos", pos, 16);
      checkOutput("load16_carry", carry, 0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      checkOutput("step16_pos", pos, 17);
      checkOutput("step16_carry", carry, 1);
      @(negedge clk);
      checkOutput("step16_carry_pulse_end", carry, 0);

      loadPos(5'd25, 5'd0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      checkOutput("step25_wrap_pos", pos, 0);
      checkOutput("step25_carry", carry, 0);

      loadPos(5'd16, 5'd0);
      load = 1'b1; step = 1'b1; pos_in = 5'd5;
      @(negedge clk);
      load = 1'b0; step = 1'b0;
      checkOutput("load_step_pos", pos, 5);
      checkOutput("load_step_carry", carry, 0);

      loadPos(5'd30, 5'd0);
      checkOutput("load30_mod_pos", pos, 4);

      loadPos(5'd0, 5'd0);
      out_ready = 1'b0;
      in_letter = 5'd0;
      in_valid  = 1'b1;
      @(negedge clk);
      in_letter = 5'd1;
      for (int c = 0; c < 10; c++) begin
         checkOutput($sformatf("stall_in_ready_%0d", c), in_ready, 0);
         checkOutput($sformatf("stall_letter_%0d", c), out_letter, 20);
         checkOutput($sformatf("stall_valid_%0d", c), out_valid, 1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("release_valid", out_valid, 1);
      checkOutput("release_letter", out_letter, 22);
      @(negedge clk);
      checkOutput("release_no_dup_valid", out_valid, 0);
      checkOutput("release_letter_hold", out_letter, 22);

      applyStimulus(5'd27);
      checkOutput("invalid_err", out_err, 1);
      checkOutput("invalid_letter", out_letter, 0);
      checkOutput("invalid_valid", out_valid, 1);
      applyStimulus(5'd9);
      checkOutput("valid_after_err_err", out_err, 0);
      checkOutput("valid_after_err_letter", out_letter, 25);

      loadPos(5'd7, 5'd0);
      out_ready = 1'b0;
      applyStimulus(5'd3);
      checkOutput("pre_reset_valid", out_valid, 1);
      checkOutput("pre_reset_pos", pos, 7);
      rst = 1'b1; in_valid = 1'b1; in_letter = 5'd2; step = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; step = 1'b0;
      checkOutput("mid_reset_valid", out_valid, 0);
      checkOutput("mid_reset_pos", pos, 0);
      checkOutput("mid_reset_letter", out_letter, 0);
      checkOutput("mid_reset_in_ready", in_ready, 1);

`ifdef ROTOR_RING_SETTING_EN
      loadPos(5'd1, 5'd1);
      applyStimulus(5'd4);
      checkOutput("ring_p1_r1_E", out_letter, 0);
      loadPos(5'd0, 5'd1);
      applyStimulus(5'd0);
      checkOutput("ring_p0_r1_A", out_letter, 10);
      loadPos(5'd3, 5'd7);
      applyStimulus(5'd12);
      checkOutput("ring_p3_r7_M", out_letter, expLetter(12, 3, 7));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
